prio_encoder4_2_hs: RTL
=======================

// Module: prio_encoder4_2_hs
// PURPOSE
//  Registered 4-to-2 encoder: the encode-side counterpart of the 2-to-4 decoder.
//  Captures single-cycle request pulses on 4 lines into sticky pending bits.
//  Reports one pending index at a time on a 2-bit code with valid/ready handshake.
//  Sits between event sources (irq/status lines) and a consumer that wants a binary index.
// PARAMETERS
//  ROUND_ROBIN  0  0: fixed priority (index 3 highest); 1: rotating priority after last grant
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  req        in   4  request pulses; req[i]=1 at an edge sets pending[i]
//  ready_in   in   1  consumer accepts idx_out when valid_out=1
//  idx_out    out  2  encoded index of the granted request
//  valid_out  out  1  idx_out is valid; held until accepted
//  pending    out  4  sticky pending request bits (status)
//  overflow   out  1  1-cycle pulse: a req hit an already-pending bit (event merged)
// BEHAVIOUR
//  Reset (async, active-high): pending=0, idx_out=0, valid_out=0, overflow=0, state=IDLE, last_grant=3.
//  Pending update, every edge: pending <= (pending & ~clr_mask) | req.
//   - clr_mask is one-hot of idx_out on an accept edge (valid_out & ready_in), else 0.
//   - Set wins: req[i] on the same edge that clears bit i leaves pending[i]=1 (new event).
//  overflow <= |(req & pending & ~clr_mask); it is registered and asserts for exactly one cycle per offending edge.
//  FSM, 2 states:
//   IDLE: valid_out=0. If pending!=0, then idx_out<=pick(pending), valid_out<=1, go to HOLD.
//         pick() uses the pending value before this edge's req.
//   HOLD: valid_out=1, idx_out frozen. New or higher-priority requests do not change idx_out.
//         If ready_in, then valid_out<=0, clear pending[idx_out], last_grant<=idx_out, go to IDLE.
//  Latency: req at edge t gives valid_out=1 after edge t+1 (pending was 0 and state IDLE).
//  Throughput: at most one accept every 2 cycles; a bubble cycle follows every accept.
//  pick(), fixed mode: the highest set index wins.
//  pick(), round-robin mode: search last_grant+1, +2, ... mod 4 and take the first set bit.
//  idx_out keeps its last value while valid_out=0; consumers ignore it then.
//  req=0 while in IDLE with pending=0: no change; valid_out stays 0.
//  Reset mid-handshake: the in-flight grant and all pending bits are dropped, nothing is reported.
//  Width rules: idx is 2 bits; round-robin pointer arithmetic wraps mod 4 (3+1 -> 0).
// STRUCTURE
//  Shared package encoder_defs: NUM_REQ=4, IDX_W=2, FSM state codes ST_IDLE/ST_HOLD.
//  Sub-module prio_pick4 (combinational): inputs vec[3:0], start[1:0], rr_en.
//   Outputs idx[1:0] and any.
//  Top block holds the pending reg, FSM, output regs, last_grant and overflow reg.
// TESTING
//  1. rst=1 mid-run -> valid_out=0, idx_out=0, pending=0, overflow=0 immediately (async).
//  2. req=0100 for 1 cycle, ready_in=1 -> valid_out=1, idx_out=2 one edge later.
//     Next edge valid_out=0 and pending=0000.
//  3. ROUND_ROBIN=0, req=1011 pulse, ready_in=1 -> grants idx 3, 1, 0 on alternating cycles.
//     pending ends 0000.
//  4. ready_in=0, req=0001, later req=1000 -> idx_out stays 0 (HOLD).
//     Raise ready_in -> accept 0, bubble, then idx 3.
//  5. req=0010 twice while pending[1]=1 -> overflow=1 for one cycle, only one grant of idx 1.
//     Same-edge accept of idx 1 with req[1]=1 -> pending[1] stays 1, no overflow, second grant issued.
//  6. ROUND_ROBIN=1, req=1111 held, ready_in=1 -> grant order 0, 1, 2, 3, 0; no index starved.

Source files
------------

// File: rtl/prio_encoder4_2_hs_pkg.sv
// Shared definitions for the registered 4-to-2 request encoder.
// Sizes, FSM state codes and a one-hot helper used by the top and the picker.
package encoder_defs;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_pick4.sv
// Combinational 4-way picker: fixed priority (index 3 highest) or
// round-robin starting just after 'start' and wrapping mod 4.
module prio_pick4
    import encoder_defs::*;
(
    input  logic [NUM_REQ-1:0] vec,
    input  logic [IDX_W-1:0]   start,
    input  logic               rr_en,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |vec;
        if (!rr_en) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            // Walk from farthest to nearest so start+1 is assigned last and wins;
            // k=NUM_REQ truncates to offset 0, making 'start' itself the lowest priority.
            for (int unsigned k = NUM_REQ; k >= 1; k--) begin
                cand = start + IDX_W'(k);
                if (vec[cand]) idx = cand;
            end
        end
    end

endmodule

// File: rtl/prio_encoder4_2_hs.sv
// Registered 4-to-2 encoder: sticky pending bits from request pulses, one
// index reported at a time on idx_out with a valid/ready handshake.
module prio_encoder4_2_hs
    import encoder_defs::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ready_in,
    output logic [IDX_W-1:0]   idx_out,
    output logic               valid_out,
    output logic [NUM_REQ-1:0] pending,
    output logic               overflow
);

    state_t             state;
    state_t             state_n;
    logic               load_idx;
    logic               accept;
    logic [NUM_REQ-1:0] clr_mask;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    prio_pick4 u_pick (
        .vec   (pending),
        .start (last_grant),
        .rr_en (ROUND_ROBIN),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign accept   = valid_out & ready_in;
    assign clr_mask = accept ? idx_onehot(idx_out) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load_idx = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_n  = ST_HOLD;
                    load_idx = 1'b1;
                end
            end
            ST_HOLD: begin
                if (ready_in) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Picker sees pending before this edge's req; set beats clear on the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= '0;
            idx_out    <= '0;
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            pending   <= (pending & ~clr_mask) | req;
            overflow  <= |(req & pending & ~clr_mask);
            valid_out <= (state_n == ST_HOLD);
            if (load_idx) idx_out    <= pick_idx;
            if (accept)   last_grant <= idx_out;
        end
    end

endmodule
